// File: rtl/conv2d_fetch_pkg.sv
// Shared types and helpers for the conv2d feature fetch mover: issue FSM encoding,
// AXI encodings and the burst-length rule (MAX_BURST cap, row remainder, 4KB boundary).
package conv2d_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [12:0] BOUNDARY_4K = 13'd4096;

    // Beats in the next burst: the smallest of the cap, the elements left in the row
    // and the beats that fit before the next 4KB page boundary.
    function automatic logic [15:0] calc_burst_len(
        input logic [11:0] addr_lo,
        input logic [15:0] remaining,
        input logic [15:0] max_burst,
        input logic [2:0]  size_log2
    );
        logic [12:0] to_bound;
        logic [15:0] beats_to_bound;
        logic [15:0] len;
        to_bound       = BOUNDARY_4K - {1'b0, addr_lo};
        beats_to_bound = {3'd0, to_bound >> size_log2};
        len            = max_burst;
        if (remaining < len) begin
            len = remaining;
        end
        if (beats_to_bound < len) begin
            len = beats_to_bound;
        end
        return len;
    endfunction

endpackage

// File: rtl/conv2d_fetch_fifo.sv
// First-word-fall-through element buffer with occupancy count; data shows on rd_data
// in the cycle valid is high, and rd_en pops it.
module conv2d_fetch_fifo
    import conv2d_fetch_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              valid,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              pop;

    assign valid   = (count_q != '0);
    assign pop     = rd_en && valid;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/conv2d_feature_fetch.sv
// AXI4 read master that streams a 2D feature map row by row as a valid/ready element stream.
// Define CONV_FETCH_PERF_EN to add the perf_stall AR-stall cycle counter output.
module conv2d_feature_fetch
    import conv2d_fetch_pkg::*;
#(
    parameter int AXI_WIDTH_ID = 4,
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int MAX_BURST    = 16,
    parameter int FIFO_DEPTH   = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    go,
    input  logic [AXI_WIDTH_AD-1:0] cfg_base,
    input  logic [15:0]             cfg_width,
    input  logic [15:0]             cfg_height,
    input  logic [AXI_WIDTH_AD-1:0] cfg_pitch,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [AXI_WIDTH_ID-1:0] M_ARID,
    output logic [AXI_WIDTH_AD-1:0] M_ARADDR,
    output logic [7:0]              M_ARLEN,
    output logic [2:0]              M_ARSIZE,
    output logic [1:0]              M_ARBURST,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [AXI_WIDTH_ID-1:0] M_RID,
    input  logic [AXI_WIDTH_DA-1:0] M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RLAST,
    input  logic                    M_RVALID,
    output logic                    M_RREADY,
    output logic [AXI_WIDTH_DA-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
`ifdef CONV_FETCH_PERF_EN
    ,
    output logic [31:0]             perf_stall
`endif
);

    localparam int               SIZE_LOG2 = $clog2(AXI_WIDTH_DA / 8);
    localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    fetch_state_e            state_q, state_d;
    logic [15:0]             row_q, row_d;
    logic [15:0]             col_q, col_d;
    logic [CNT_W-1:0]        outstanding_q, outstanding_d;
    logic                    arvalid_q, arvalid_d;
    logic [AXI_WIDTH_AD-1:0] araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic                    error_q, error_d;
    logic                    done_q, done_d;
    logic [31:0]             delivered_q, delivered_d;

    // Frame configuration and row accumulator; only meaningful once a frame starts.
    logic [15:0]             width_q, width_d;
    logic [15:0]             height_q, height_d;
    logic [AXI_WIDTH_AD-1:0] pitch_q, pitch_d;
    logic [31:0]             total_q, total_d;
    logic [AXI_WIDTH_AD-1:0] row_addr_q, row_addr_d;

    logic [AXI_WIDTH_AD-1:0] cur_addr;
    logic [15:0]             burst_len;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W-1:0]        credit;
    logic                    can_issue;
    logic [8:0]              ar_beats;
    logic [15:0]             col_next;
    logic                    ar_hs;
    logic                    r_beat;
    logic                    pop;
    logic                    fifo_valid;
    logic [AXI_WIDTH_DA-1:0] fifo_data;
    logic                    unused_r_sideband;

    assign unused_r_sideband = ^{M_RID, M_RLAST};

    assign cur_addr  = row_addr_q + (AXI_WIDTH_AD'(col_q) << SIZE_LOG2);
    assign burst_len = calc_burst_len(cur_addr[11:0], width_q - col_q,
                                      16'(MAX_BURST), 3'(SIZE_LOG2));
    // Beats already promised to the buffer count against it so R never needs back-pressure.
    assign credit    = DEPTH_C - fifo_count - outstanding_q;
    assign can_issue = (16'(credit) >= burst_len);
    assign ar_beats  = {1'b0, arlen_q} + 9'd1;
    assign col_next  = col_q + 16'(ar_beats);
    assign ar_hs     = arvalid_q && M_ARREADY;
    // Stray beats from before a reset are dropped: nothing is outstanding in IDLE.
    assign r_beat    = M_RVALID && (state_q != ST_IDLE) && (outstanding_q != '0);
    assign pop       = fifo_valid && out_ready;

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        arvalid_d     = arvalid_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        error_d       = error_q;
        done_d        = 1'b0;
        delivered_d   = delivered_q;
        width_d       = width_q;
        height_d      = height_q;
        pitch_d       = pitch_q;
        total_d       = total_q;
        row_addr_d    = row_addr_q;
        outstanding_d = outstanding_q
                      + (ar_hs ? CNT_W'(ar_beats) : '0)
                      - (r_beat ? ONE_C : '0);

        if (pop) begin
            delivered_d = delivered_q + 32'd1;
        end
        if (r_beat && (M_RRESP != RESP_OKAY)) begin
            error_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    error_d     = 1'b0;
                    delivered_d = '0;
                    if ((cfg_width == '0) || (cfg_height == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        width_d    = cfg_width;
                        height_d   = cfg_height;
                        pitch_d    = cfg_pitch;
                        total_d    = 32'(cfg_width) * 32'(cfg_height);
                        row_addr_d = cfg_base;
                        row_d      = '0;
                        col_d      = '0;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!arvalid_q) begin
                    if (can_issue) begin
                        arvalid_d = 1'b1;
                        araddr_d  = cur_addr;
                        arlen_d   = 8'(burst_len - 16'd1);
                    end
                end else if (M_ARREADY) begin
                    arvalid_d = 1'b0;
                    if (col_next == width_q) begin
                        col_d      = '0;
                        row_d      = row_q + 16'd1;
                        row_addr_d = row_addr_q + pitch_q;
                        if (row_q == (height_q - 16'd1)) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        col_d = col_next;
                    end
                end
            end
            ST_DRAIN: begin
                if ((outstanding_q == '0) && (fifo_count == '0)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            col_q         <= '0;
            outstanding_q <= '0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            error_q       <= 1'b0;
            done_q        <= 1'b0;
            delivered_q   <= '0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            outstanding_q <= outstanding_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            error_q       <= error_d;
            done_q        <= done_d;
            delivered_q   <= delivered_d;
        end
    end

    always_ff @(posedge ACLK) begin
        width_q    <= width_d;
        height_q   <= height_d;
        pitch_q    <= pitch_d;
        total_q    <= total_d;
        row_addr_q <= row_addr_d;
    end

    conv2d_fetch_fifo #(
        .DATA_W (AXI_WIDTH_DA),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .wr_en   (r_beat),
        .wr_data (M_RDATA),
        .rd_en   (out_ready),
        .rd_data (fifo_data),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

`ifdef CONV_FETCH_PERF_EN
    logic [31:0] perf_q, perf_d;
    logic        ar_stalled;

    assign ar_stalled = (state_q == ST_ISSUE)
                     && ((arvalid_q && !M_ARREADY) || (!arvalid_q && !can_issue));

    always_comb begin
        perf_d = perf_q;
        if ((state_q == ST_IDLE) && go) begin
            perf_d = '0;
        end else if (ar_stalled && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall = perf_q;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign error     = error_q;
    assign M_ARID    = '0;
    assign M_ARADDR  = araddr_q;
    assign M_ARLEN   = arlen_q;
    assign M_ARSIZE  = 3'(SIZE_LOG2);
    assign M_ARBURST = BURST_INCR;
    assign M_ARVALID = arvalid_q;
    assign M_RREADY  = 1'b1;
    assign out_data  = fifo_data;
    assign out_valid = fifo_valid;
    assign out_last  = fifo_valid && (delivered_q == (total_q - 32'd1));

endmodule

// File: tb/tb_conv2d_feature_fetch.sv
// Randomized bench for conv2d_feature_fetch: an AXI slave with random delays, a frame-level
// reference model of bursts and elements, and directed frames for boundary cases.
module tb_conv2d_feature_fetch;

    localparam int MAXB  = 16;
    localparam int DEPTH = 32;

    typedef struct { logic [31:0] addr; int len; } burst_t;
    typedef struct { logic [31:0] addr; bit last; } beat_t;
    typedef struct { logic [31:0] data; bit last; } elem_t;

    logic        ACLK, ARESETn, go;
    logic [31:0] cfg_base, cfg_pitch;
    logic [15:0] cfg_width, cfg_height;
    logic        busy, done, error;
    logic [3:0]  M_ARID, M_RID;
    logic [31:0] M_ARADDR, M_RDATA, out_data;
    logic [7:0]  M_ARLEN;
    logic [2:0]  M_ARSIZE;
    logic [1:0]  M_ARBURST, M_RRESP;
    logic        M_ARVALID, M_ARREADY, M_RLAST, M_RVALID, M_RREADY;
    logic        out_valid, out_ready, out_last;
`ifdef CONV_FETCH_PERF_EN
    logic [31:0] perf_stall;
`endif

    conv2d_feature_fetch #(
        .AXI_WIDTH_ID(4), .AXI_WIDTH_AD(32), .AXI_WIDTH_DA(32),
        .MAX_BURST(MAXB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .go(go),
        .cfg_base(cfg_base), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_pitch(cfg_pitch), .busy(busy), .done(done), .error(error),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
        .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
`ifdef CONV_FETCH_PERF_EN
        , .perf_stall(perf_stall)
`endif
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory contents as a pure function of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    burst_t exp_ar_q[$];
    burst_t ar_log[$];
    elem_t  exp_el_q[$];
    beat_t  beat_q[$];

    int ar_pct, r_pct, out_pct, hold_cnt, err_beat, beat_no;
    int done_cnt, issued, popped, max_level, ar_cycles, stab_err, rready_drop;
    bit busy_seen, go_req, ar_wait;
    logic [31:0] ar_wait_addr;
    logic [7:0]  ar_wait_len;

    task automatic build_model(input logic [31:0] base, input int w, input int h,
                               input logic [31:0] pitch);
        exp_ar_q.delete();
        exp_el_q.delete();
        for (int r = 0; r < h; r++) begin
            logic [31:0] ra;
            int c;
            ra = base + pitch * 32'(r);
            c  = 0;
            while (c < w) begin
                logic [31:0] a;
                int to_b, len;
                a    = ra + 32'(c) * 32'd4;
                to_b = (4096 - int'(a % 32'd4096)) / 4;
                len  = MAXB;
                if (w - c < len) len = w - c;
                if (to_b < len) len = to_b;
                exp_ar_q.push_back('{a, len});
                c += len;
            end
            for (int k = 0; k < w; k++) begin
                exp_el_q.push_back('{mem_word(ra + 32'(k) * 32'd4), (r * w + k == w * h - 1)});
            end
        end
    endtask

    // One clock: drive slave/sink inputs at the falling edge, then record the handshakes
    // that the following rising edge will complete.
    task automatic step();
        @(negedge ACLK);
        go     = go_req;
        go_req = 1'b0;
        if (beat_q.size() != 0 && $urandom_range(99) < r_pct) begin
            beat_t b;
            b        = beat_q.pop_front();
            M_RVALID = 1'b1;
            M_RDATA  = mem_word(b.addr);
            M_RRESP  = (beat_no == err_beat) ? 2'b10 : 2'b00;
            M_RLAST  = b.last;
            beat_no++;
        end else begin
            M_RVALID = 1'b0;
            M_RDATA  = $urandom;
            M_RRESP  = 2'b00;
            M_RLAST  = 1'b0;
        end
        M_ARREADY = ($urandom_range(99) < ar_pct);
        if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
        end else begin
            out_ready = ($urandom_range(99) < out_pct);
        end

        if (M_RREADY !== 1'b1) rready_drop++;
        if (busy) busy_seen = 1'b1;
        if (M_ARVALID) ar_cycles++;
        if (ar_wait && (!M_ARVALID || M_ARADDR != ar_wait_addr || M_ARLEN != ar_wait_len))
            stab_err++;
        ar_wait      = M_ARVALID && !M_ARREADY;
        ar_wait_addr = M_ARADDR;
        ar_wait_len  = M_ARLEN;

        if (M_ARVALID && M_ARREADY) begin
            if (exp_ar_q.size() == 0) begin
                check_eq("ar_unexpected", 64'(M_ARADDR), 64'hFFFF_FFFF_FFFF);
            end else begin
                burst_t e;
                e = exp_ar_q.pop_front();
                check_eq("araddr", 64'(M_ARADDR), 64'(e.addr));
                check_eq("arlen", 64'(M_ARLEN), 64'(e.len - 1));
                check_eq("ar_attr", 64'({M_ARID, M_ARSIZE, M_ARBURST}), 64'({4'd0, 3'd2, 2'd1}));
            end
            ar_log.push_back('{M_ARADDR, int'(M_ARLEN) + 1});
            for (int k = 0; k <= int'(M_ARLEN); k++)
                beat_q.push_back('{M_ARADDR + 32'(k) * 32'd4, (k == int'(M_ARLEN))});
            issued += int'(M_ARLEN) + 1;
        end
        if (out_valid && out_ready) begin
            if (exp_el_q.size() == 0) begin
                check_eq("elem_unexpected", 64'(out_data), 64'hFFFF_FFFF_FFFF);
            end else begin
                elem_t e;
                e = exp_el_q.pop_front();
                check_eq("out_data", 64'(out_data), 64'(e.data));
                check_eq("out_last", 64'(out_last), 64'(e.last));
            end
            popped++;
        end
        if (done) done_cnt++;
        if (issued - popped > max_level) max_level = issued - popped;
    endtask

    task automatic start_frame(input logic [31:0] base, input int w, input int h,
                               input logic [31:0] pitch, input int ebeat,
                               input int arp, input int rp, input int op, input int hold);
        build_model(base, w, h, pitch);
        ar_log.delete();
        ar_pct = arp; r_pct = rp; out_pct = op; hold_cnt = hold; err_beat = ebeat;
        beat_no = 0; done_cnt = 0; issued = 0; popped = 0; max_level = 0;
        ar_cycles = 0; stab_err = 0; rready_drop = 0; busy_seen = 1'b0;
        cfg_base = base; cfg_width = 16'(w); cfg_height = 16'(h); cfg_pitch = pitch;
        go_req = 1'b1;
        step();
    endtask

    task automatic finish_frame(input logic exp_err, output int done_lat);
        int n;
        step();
        n = 1;
        check_eq("err_clr", 64'(error), 64'd0);
        while (done_cnt == 0 && n < 20000) begin
            step();
            n++;
        end
        if (done_cnt == 0) check_eq("done_timeout", 64'd0, 64'd1);
        done_lat = n;
        step();
        step();
        check_eq("done_pulses", 64'(done_cnt), 64'd1);
        check_eq("ar_left", 64'(exp_ar_q.size()), 64'd0);
        check_eq("elem_left", 64'(exp_el_q.size()), 64'd0);
        check_eq("busy_end", 64'({busy, out_valid}), 64'd0);
        check_eq("error_end", 64'(error), 64'(exp_err));
        check_eq("rready_drop", 64'(rready_drop), 64'd0);
        check_eq("ar_stable", 64'(stab_err), 64'd0);
        check_eq("credit_bound", 64'(max_level <= DEPTH), 64'd1);
    endtask

    initial begin
        int lat;
        ARESETn = 1'b0; go = 1'b0; go_req = 1'b0; ar_wait = 1'b0;
        cfg_base = '0; cfg_width = '0; cfg_height = '0; cfg_pitch = '0;
        M_ARREADY = 1'b0; M_RID = '0; M_RDATA = '0; M_RRESP = '0; M_RLAST = 1'b0;
        M_RVALID = 1'b0; out_ready = 1'b0;
        hold_cnt = 0; err_beat = -1;
        repeat (3) @(negedge ACLK);
        check_eq("rst_ctrl", 64'({busy, done, error, M_ARVALID, out_valid, out_last}), 64'd0);
        check_eq("rst_addr", 64'(M_ARADDR), 64'd0);
        check_eq("rst_len", 64'(M_ARLEN), 64'd0);
        ARESETn = 1'b1;

        // Zero-delay slave, regular 8x4 frame.
        start_frame(32'h1000, 8, 4, 32'd64, -1, 100, 100, 100, 0);
        finish_frame(1'b0, lat);
        check_eq("a_ar_count", 64'(ar_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < ar_log.size(); i++) begin
            check_eq($sformatf("a_ar%0d_addr", i), 64'(ar_log[i].addr), 64'(32'h1000 + 32'(i) * 32'h40));
            check_eq($sformatf("a_ar%0d_len", i), 64'(ar_log[i].len), 64'd8);
        end
        check_eq("a_popped", 64'(popped), 64'd32);

        // Row crossing a 4KB page.
        start_frame(32'h0FF0, 40, 2, 32'h100, -1, 70, 60, 80, 0);
        finish_frame(1'b0, lat);
        if (ar_log.size() >= 4) begin
            check_eq("b_ar0", 64'({ar_log[0].addr, 8'(ar_log[0].len)}), 64'({32'h0FF0, 8'd4}));
            check_eq("b_ar1", 64'({ar_log[1].addr, 8'(ar_log[1].len)}), 64'({32'h1000, 8'd16}));
            check_eq("b_ar2", 64'({ar_log[2].addr, 8'(ar_log[2].len)}), 64'({32'h1040, 8'd16}));
            check_eq("b_ar3", 64'({ar_log[3].addr, 8'(ar_log[3].len)}), 64'({32'h1080, 8'd4}));
        end else begin
            check_eq("b_ar_count", 64'(ar_log.size()), 64'd4);
        end

        // Sink stalled for 200 cycles: issue must stop at the buffer depth.
        start_frame(32'h2000, 64, 2, 32'h100, -1, 100, 100, 100, 200);
        finish_frame(1'b0, lat);
        check_eq("hold_fill", 64'(max_level), 64'(DEPTH));

        // SLVERR on the 5th beat, then the next go clears the flag.
        start_frame(32'h3000, 16, 1, 32'h40, 4, 100, 100, 100, 0);
        finish_frame(1'b1, lat);
        start_frame(32'h3100, 4, 1, 32'h40, -1, 100, 100, 100, 0);
        finish_frame(1'b0, lat);

        // Empty frame.
        start_frame(32'h4000, 0, 3, 32'h40, -1, 100, 100, 100, 0);
        finish_frame(1'b0, lat);
        check_eq("zero_lat", 64'(lat), 64'd1);
        check_eq("zero_busy", 64'(busy_seen), 64'd0);
        check_eq("zero_ar", 64'(ar_cycles), 64'd0);

        // Randomized frames, including address wrap and random channel delays.
        for (int t = 0; t < 8; t++) begin
            start_frame($urandom & 32'hFFFF_FFFC, $urandom_range(1, 50), $urandom_range(1, 4),
                        32'($urandom_range(0, 1023)) << 2, -1,
                        $urandom_range(20, 100), $urandom_range(20, 100),
                        $urandom_range(20, 100), 0);
            finish_frame(1'b0, lat);
            check_eq("rnd_popped", 64'(popped), 64'(int'(cfg_width) * int'(cfg_height)));
        end

        // Reset mid-frame, then a fresh 4-element frame.
        start_frame(32'h5000, 64, 4, 32'h100, -1, 80, 80, 80, 0);
        repeat (60) step();
        ARESETn = 1'b0;
        M_RVALID = 1'b0; M_ARREADY = 1'b0; go = 1'b0;
        #1;
        check_eq("mid_rst_ctrl", 64'({busy, done, error, M_ARVALID, out_valid, out_last}), 64'd0);
        check_eq("mid_rst_ar", 64'({M_ARADDR, M_ARLEN}), 64'd0);
        beat_q.delete();
        ar_wait = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESETn = 1'b1;
        start_frame(32'h6000, 4, 1, 32'h40, -1, 100, 100, 100, 0);
        finish_frame(1'b0, lat);
        check_eq("post_rst_popped", 64'(popped), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
